// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   IF-stage controller that sequences the PC register and the instruction
//   memory fetch handshake. Each cycle it selects the next PC from one of three
//   sources: sequential increment, MEM-stage branch redirect, or a hazard stall.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   pc_cur                     current PC (PC register output)
//   stall                      load-use hazard stall request
//   branch_taken/_target       MEM-stage taken branch and its target
//   imem_ack                   instruction memory data valid for imem_addr
//   pc_next, pc_write          PC register PCIn / PCWrite
//   imem_req, imem_addr        fetch request and address (= pc_cur)
//   ifid_write, flush          IF/ID capture enable; pipeline squash
//   fetch_count                instructions delivered to IF/ID
//   bus_err                    sticky fetch timeout
module fetch_sequencer #(
  parameter int unsigned          ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              ifid_write,
  output logic              flush,
  output logic [31:0]       fetch_count,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_STALL,
    S_REDIRECT,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  logic [7:0]          wait_inc;
  logic [ADDR_W-1:0]   saved_q, saved_d;
  logic [31:0]         count_q, count_d;

  assign imem_addr   = pc_cur;
  assign fetch_count = count_q;
  assign wait_inc    = wait_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      wait_q  <= '0;
      saved_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      saved_q <= saved_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    saved_d    = saved_q;
    count_d    = count_q;
    pc_next    = pc_cur;
    pc_write   = 1'b0;
    imem_req   = 1'b0;
    ifid_write = 1'b0;
    flush      = 1'b0;
    bus_err    = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        pc_next  = RESET_PC;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          flush = 1'b1;
          if (imem_ack) begin
            pc_next  = branch_target;
            pc_write = 1'b1;
          end else begin
            saved_d = branch_target;
            state_d = S_REDIRECT;
          end
        end else if (stall && imem_ack) begin
          state_d = S_STALL;
        end else if (imem_ack) begin
          pc_next    = pc_cur + ADDR_W'(4);
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          count_d    = count_q + 32'd1;
        end
      end
      S_STALL: begin
        if (branch_taken) begin
          pc_next  = branch_target;
          pc_write = 1'b1;
          flush    = 1'b1;
          state_d  = S_FETCH;
        end else if (!stall) begin
          state_d = S_FETCH;
        end
      end
      S_REDIRECT: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          flush   = 1'b1;
          saved_d = branch_target;
        end
        if (imem_ack) begin
          // A branch resolving in the same cycle as the ack supersedes the saved target.
          pc_next  = branch_taken ? branch_target : saved_q;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_ERR: begin
        bus_err = 1'b1;
      end
      default: state_d = S_BOOT;
    endcase

    // Timeout overrides any transition chosen above.
    if (imem_req && !imem_ack) begin
      wait_d = wait_inc;
      if (32'(wait_inc) >= MAX_WAIT)
        state_d = S_ERR;
    end else begin
      wait_d = '0;
    end

    // State is already BOOT during reset; mask BOOT's pc_write until release.
    if (reset) begin
      pc_next    = RESET_PC;
      pc_write   = 1'b0;
      imem_req   = 1'b0;
      ifid_write = 1'b0;
      flush      = 1'b0;
      bus_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int unsigned AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_cur;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          imem_ack;
  logic [AW-1:0] pc_next;
  logic          pc_write;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          ifid_write;
  logic          flush;
  logic [31:0]   fetch_count;
  logic          bus_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [AW-1:0] exp_pc_q[$];
  logic          rec_pw;
  logic [AW-1:0] rec_pn;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(64), .RESET_PC('0), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_ack(imem_ack), .pc_next(pc_next), .pc_write(pc_write),
    .imem_req(imem_req), .imem_addr(imem_addr), .ifid_write(ifid_write),
    .flush(flush), .fetch_count(fetch_count), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Negedge sample: every PC load is matched against the scoreboard.
  task automatic half();
    logic [AW-1:0] e;
    @(negedge clk);
    if (pc_write) begin
      if (exp_pc_q.size() == 0) begin
        check("pcw_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_pc_q.pop_front();
        check("pc_next", pc_next, e);
      end
    end
    rec_pw = pc_write;
    rec_pn = pc_next;
  endtask

  // Posedge: the bench plays the PC register.
  task automatic fin();
    @(posedge clk);
    #1;
    if (rec_pw) pc_cur = rec_pn;
  endtask

  task automatic cyc();
    half();
    fin();
  endtask

  initial begin
    reset = 1'b1; pc_cur = '0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = '0; imem_ack = 1'b0; rec_pw = 1'b0; rec_pn = '0;

    // 1: reset, then sequential fetch with ack every cycle
    for (int i = 0; i < 3; i++) begin
      half();
      check("rst_req", imem_req, 0);
      check("rst_pcw", pc_write, 0);
      check("rst_pcnext", pc_next, 0);
      check("rst_count", fetch_count, 0);
      check("rst_buserr", bus_err, 0);
      fin();
    end
    reset = 1'b0;
    imem_ack = 1'b1;
    exp_pc_q.push_back(64'd0);
    exp_pc_q.push_back(64'd4);
    exp_pc_q.push_back(64'd8);
    exp_pc_q.push_back(64'd12);
    exp_pc_q.push_back(64'd16);
    for (int i = 0; i < 5; i++) cyc();
    imem_ack = 1'b0;
    half();
    check("t1_count", fetch_count, 4);
    check("t1_pc", pc_cur, 16);
    check("t1_addr", imem_addr, 16);
    fin();

    // 2: delayed ack holds request
    pc_cur = 64'h100;
    for (int i = 0; i < 3; i++) begin
      half();
      check("t2_req_wait", imem_req, 1);
      check("t2_pcw_wait", pc_write, 0);
      fin();
    end
    imem_ack = 1'b1;
    exp_pc_q.push_back(64'h104);
    half();
    check("t2_req_ack", imem_req, 1);
    check("t2_ifid", ifid_write, 1);
    fin();
    imem_ack = 1'b0;
    check("t2_count", fetch_count, 5);

    // 3: stall with ack, then refetch same PC
    pc_cur = 64'h200;
    stall = 1'b1;
    imem_ack = 1'b1;
    half();
    check("t3_pcw", pc_write, 0);
    check("t3_ifid", ifid_write, 0);
    fin();
    half();
    check("t3_req_stall", imem_req, 0);
    check("t3_pcw_stall", pc_write, 0);
    fin();
    stall = 1'b0;
    half();
    check("t3_req_rel", imem_req, 0);
    fin();
    exp_pc_q.push_back(64'h204);
    half();
    check("t3_refetch_addr", imem_addr, 64'h200);
    check("t3_refetch_ifid", ifid_write, 1);
    fin();
    imem_ack = 1'b0;
    check("t3_count", fetch_count, 6);

    // 4: branch without ack -> redirect, word discarded
    branch_taken = 1'b1;
    branch_target = 64'h400;
    half();
    check("t4_flush", flush, 1);
    check("t4_pcw", pc_write, 0);
    check("t4_ifid", ifid_write, 0);
    fin();
    branch_taken = 1'b0;
    branch_target = 64'h0;
    half();
    check("t4_req", imem_req, 1);
    check("t4_flush_once", flush, 0);
    fin();
    cyc();
    imem_ack = 1'b1;
    exp_pc_q.push_back(64'h400);
    half();
    check("t4_ack_ifid", ifid_write, 0);
    check("t4_ack_pcw", pc_write, 1);
    fin();
    imem_ack = 1'b0;
    check("t4_count", fetch_count, 6);
    check("t4_pc", pc_cur, 64'h400);

    // 5: PC wrap, then timeout
    pc_cur = 64'hFFFF_FFFF_FFFF_FFFC;
    imem_ack = 1'b1;
    exp_pc_q.push_back(64'h0);
    half();
    check("t5_ifid", ifid_write, 1);
    fin();
    imem_ack = 1'b0;
    check("t5_count", fetch_count, 7);
    for (int i = 0; i < 15; i++) begin
      half();
      check("t5_req_wait", imem_req, 1);
      check("t5_no_err_yet", bus_err, 0);
      fin();
    end
    half();
    check("t5_buserr", bus_err, 1);
    check("t5_req_err", imem_req, 0);
    fin();
    imem_ack = 1'b1;
    stall = 1'b0;
    half();
    check("t5_sticky", bus_err, 1);
    check("t5_pcw_err", pc_write, 0);
    fin();
    reset = 1'b1;
    #1;
    check("t5_rst_buserr", bus_err, 0);
    check("t5_rst_count", fetch_count, 0);
    fin();
    reset = 1'b0;

    // 6: reset mid-redirect
    exp_pc_q.push_back(64'h0);
    exp_pc_q.push_back(64'h4);
    cyc();
    cyc();
    check("t6_count1", fetch_count, 1);
    imem_ack = 1'b0;
    branch_taken = 1'b1;
    branch_target = 64'h800;
    half();
    check("t6_flush", flush, 1);
    fin();
    branch_taken = 1'b0;
    half();
    check("t6_req_redir", imem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_req_drop", imem_req, 0);
    check("t6_count_clr", fetch_count, 0);
    fin();
    reset = 1'b0;
    exp_pc_q.push_back(64'h0);
    half();
    check("t6_boot_pcw", pc_write, 1);
    fin();

    check("sb_empty", 64'(exp_pc_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
